// File: rtl/mem_scrubber_pkg.sv
// Shared definitions for the SRAM fill/check/scrub engine: defaults, mode and state encodings.
package mem_scrubber_pkg;

    localparam int          DEF_N_BANKS = 20;
    localparam int          DEF_ADDR_W  = 9;
    localparam int          DEF_CNT_W   = 16;
    localparam logic [7:0]  DEF_PATTERN = 8'h55;
    // Bank field of last_err_loc is fixed at 5 bits, so at most 32 banks.
    localparam int          BANK_W      = 5;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_SCRUB = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CMP    = 3'd3,
        ST_REPAIR = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Checkerboard: odd byte addresses hold the inverted pattern.
    function automatic logic [7:0] expected_byte(input logic [7:0] pattern, input logic addr_lsb);
        return pattern ^ {8{addr_lsb}};
    endfunction

endpackage

// File: rtl/scrub_addr_gen.sv
// Bank/byte sweep counter with end-of-sweep flag and one-hot bank select decode.
module scrub_addr_gen
    import mem_scrubber_pkg::*;
#(
    parameter int N_BANKS = DEF_N_BANKS,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_step,
    output logic [BANK_W-1:0]  o_bank,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_last,
    output logic [N_BANKS-1:0] o_cs_onehot
);

    assign o_last = (o_bank == BANK_W'(N_BANKS - 1)) && (o_addr == '1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bank <= '0;
            o_addr <= '0;
        end else if (i_clear) begin
            o_bank <= '0;
            o_addr <= '0;
        end else if (i_step) begin
            o_addr <= o_addr + 1'b1;
            if (o_addr == '1) begin
                o_bank <= o_last ? '0 : o_bank + 1'b1;
            end
        end
    end

    always_comb begin
        o_cs_onehot = '0;
        for (int i = 0; i < N_BANKS; i++) begin
            if (o_bank == BANK_W'(i)) begin
                o_cs_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_scrubber.sv
// Built-in fill/check/scrub engine sweeping every bank and byte of the SRAM test array.
module mem_scrubber
    import mem_scrubber_pkg::*;
#(
    parameter int         N_BANKS = DEF_N_BANKS,
    parameter int         ADDR_W  = DEF_ADDR_W,
    parameter logic [7:0] PATTERN = DEF_PATTERN,
    parameter int         CNT_W   = DEF_CNT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [1:0]               i_mode,
    input  logic                     i_grant,
    input  logic [7:0]               i_rd_data,
    output logic                     o_req,
    output logic [N_BANKS-1:0]       o_mem_cs,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic                     o_mem_rw,
    output logic [7:0]               o_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_err_count,
    output logic [BANK_W+ADDR_W-1:0] o_last_err_loc,
    output logic [7:0]               o_last_err_dat,
    output logic [2:0]               o_dbg_state
);

    // Bus handshake: o_req stays high for the whole sweep; an access happens only in a
    // cycle where i_grant is high, and a pending access simply holds until granted.
    state_t             state, state_d;
    mode_t              mode_q;
    logic [7:0]         rd_q;
    logic [BANK_W-1:0]  bank;
    logic [ADDR_W-1:0]  addr;
    logic               last;
    logic [N_BANKS-1:0] cs_onehot;
    logic               clear, step;
    logic               start_ok, drive, mismatch;
    logic [7:0]         expected;

    scrub_addr_gen #(
        .N_BANKS (N_BANKS),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (clear),
        .i_step      (step),
        .o_bank      (bank),
        .o_addr      (addr),
        .o_last      (last),
        .o_cs_onehot (cs_onehot)
    );

    assign expected = expected_byte(PATTERN, addr[0]);
    assign start_ok = i_start && (i_mode != MODE_RSVD);
    assign mismatch = (rd_q != expected);
    assign drive    = (state == ST_ISSUE) || (state == ST_REPAIR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        clear   = 1'b0;
        step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    clear   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_grant) begin
                    state_d = (mode_q == MODE_FILL) ? ST_NEXT : ST_WAIT;
                end
            end
            ST_WAIT:   state_d = ST_CMP;
            ST_CMP:    state_d = (mismatch && (mode_q == MODE_SCRUB)) ? ST_REPAIR : ST_NEXT;
            ST_REPAIR: begin
                if (i_grant) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                step    = 1'b1;
                state_d = last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // cs is decoded combinationally from state, so an async reset drops it at once.
    assign o_mem_cs    = (drive && i_grant) ? cs_onehot : '0;
    assign o_mem_addr  = addr;
    assign o_mem_rw    = (state == ST_ISSUE) && (mode_q != MODE_FILL);
    assign o_wr_data   = drive ? expected : 8'h00;
    assign o_busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign o_req       = o_busy;
    assign o_done      = (state == ST_DONE);
    assign o_dbg_state = state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q         <= MODE_FILL;
            rd_q           <= 8'h00;
            o_err_count    <= '0;
            o_last_err_loc <= '0;
            o_last_err_dat <= 8'h00;
        end else begin
            if ((state == ST_IDLE) && start_ok) begin
                mode_q         <= mode_t'(i_mode);
                o_err_count    <= '0;
                o_last_err_loc <= '0;
                o_last_err_dat <= 8'h00;
            end
            // Read data is valid exactly one cycle after the granted read, i.e. in WAIT.
            if (state == ST_WAIT) begin
                rd_q <= i_rd_data;
            end
            if ((state == ST_CMP) && mismatch) begin
                if (o_err_count != '1) begin
                    o_err_count <= o_err_count + 1'b1;
                end
                o_last_err_loc <= {bank, addr};
                o_last_err_dat <= rd_q;
            end
        end
    end

endmodule
